// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the ALU/hazard logic and the iterative divider.
interface div_unit_if #(parameter int XLEN = 32);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    modport master (output start, op, dividend, divisor, flush, input busy, done, result);
    modport slave  (input start, op, dividend, divisor, flush, output busy, done, result);
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative RV32M divider (DIV/DIVU/REM/REMU), one restoring step per cycle,
// sign fix-up in a final cycle, divide-by-zero and signed overflow resolved at start.
module div_unit #(parameter int XLEN = 32) (
    input logic        CLK,
    input logic        RESET,
    div_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
    state_t          r_state, w_next;
    logic [1:0]      r_op;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_quo, r_dvs, r_result;
    logic            r_neg_q, r_neg_r;
    logic [4:0]      r_cnt;
    logic            w_signed, w_a_neg, w_b_neg, w_div0, w_ovf, w_special, w_accept, w_ge, w_neg;
    logic [XLEN-1:0] w_a_abs, w_b_abs, w_spec_res, w_mag;
    logic [XLEN:0]   w_shift, w_diff;
    assign w_signed   = ~bus.op[0];
    assign w_a_neg    = w_signed & bus.dividend[XLEN-1];
    assign w_b_neg    = w_signed & bus.divisor[XLEN-1];
    assign w_a_abs    = w_a_neg ? -bus.dividend : bus.dividend;
    assign w_b_abs    = w_b_neg ? -bus.divisor : bus.divisor;
    assign w_div0     = bus.divisor == '0;
    assign w_ovf      = w_signed && bus.dividend == {1'b1, {(XLEN-1){1'b0}}} && bus.divisor == '1;
    assign w_special  = w_div0 | w_ovf;
    // on signed overflow the quotient equals the dividend (most negative value)
    assign w_spec_res = w_div0 ? (bus.op[1] ? bus.dividend : '1) : (bus.op[1] ? '0 : bus.dividend);
    assign w_accept   = bus.start && !bus.flush && (r_state == IDLE || r_state == DONE);
    assign w_shift    = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_ge       = r_rem[XLEN] | (w_shift >= {1'b0, r_dvs});
    assign w_mag      = r_op[1] ? r_rem[XLEN-1:0] : r_quo;
    assign w_neg      = r_op[1] ? r_neg_r : r_neg_q;
    assign bus.busy   = r_state == CALC || r_state == SIGN;
    assign bus.done   = r_state == DONE;
    assign bus.result = r_result;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_next = bus.flush ? IDLE :
                 w_accept ? (w_special ? DONE : CALC) :
                 r_state == CALC ? (r_cnt == 5'd31 ? SIGN : CALC) :
                 r_state == SIGN ? DONE :
                 r_state == DONE ? IDLE : r_state;
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_op     <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op     <= bus.op;
            r_rem    <= '0;
            r_quo    <= w_a_abs;
            r_dvs    <= w_b_abs;
            r_neg_q  <= bus.op == 2'b00 && (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
            r_neg_r  <= bus.op == 2'b10 && bus.dividend[XLEN-1];
            r_cnt    <= '0;
            if (w_special) r_result <= w_spec_res;
        end else if (r_state == CALC) begin
            r_rem    <= w_ge ? w_diff : w_shift;
            r_quo    <= {r_quo[XLEN-2:0], w_ge};
            r_cnt    <= r_cnt + 5'd1;
        end else if (r_state == SIGN && !bus.flush) begin
            r_result <= w_neg ? -w_mag : w_mag;
        end
    end
endmodule
